// File: rtl/interp_tap_seq.sv
// rtl/interp_tap_seq.sv - HEVC interpolation tap sequencer feeding a signed MAC.
// One job = clear, then N sample x coefficient taps, then a 1-cycle result flag.
module interp_tap_seq #(
  parameter int SAMPLE_BITS = 16,
  parameter int A_BITS      = 16,
  parameter int B_BITS      = 8,
  parameter int TAG_BITS    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*SAMPLE_BITS-1:0] in_samples,
  input  logic [2:0]               in_frac,
  input  logic                     in_chroma,
  input  logic [TAG_BITS-1:0]      in_tag,
  output logic                     mac_rst,
  output logic                     mac_en,
  output logic [A_BITS-1:0]        mac_a,
  output logic [B_BITS-1:0]        mac_b,
  output logic                     res_valid,
  output logic [TAG_BITS-1:0]      res_tag,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CLR, TAP, DONE} state_t;

  localparam logic signed [7:0] LUMA [4][8] = '{
    '{ 8'sd0,  8'sd0,   8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,  8'sd1,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11, 8'sd4, -8'sd1},
    '{ 8'sd0,  8'sd1,  -8'sd5,  8'sd17,  8'sd58, -8'sd10, 8'sd4, -8'sd1}
  };

  localparam logic signed [7:0] CHROMA [8][4] = '{
    '{ 8'sd0, 8'sd64,  8'sd0,  8'sd0},
    '{-8'sd2, 8'sd58, 8'sd10, -8'sd2},
    '{-8'sd4, 8'sd54, 8'sd16, -8'sd2},
    '{-8'sd6, 8'sd46, 8'sd28, -8'sd4},
    '{-8'sd4, 8'sd36, 8'sd36, -8'sd4},
    '{-8'sd4, 8'sd28, 8'sd46, -8'sd6},
    '{-8'sd2, 8'sd16, 8'sd54, -8'sd4},
    '{-8'sd2, 8'sd10, 8'sd58, -8'sd2}
  };

  state_t                     state, state_next;
  logic [2:0]                 k, k_next;
  logic [8*SAMPLE_BITS-1:0]   samples;
  logic [2:0]                 frac;
  logic                       chroma;
  logic [TAG_BITS-1:0]        tag;
  logic                       accept;
  logic [2:0]                 last_k;
  logic signed [SAMPLE_BITS-1:0] sample_sel;
  logic signed [7:0]          coef_sel;

  assign accept     = in_valid & in_ready;
  assign last_k     = chroma ? 3'd3 : 3'd7;
  assign sample_sel = samples[k*SAMPLE_BITS +: SAMPLE_BITS];
  // Luma only has four filters, so frac[2] never reaches the luma ROM index.
  assign coef_sel   = chroma ? CHROMA[frac][k[1:0]] : LUMA[frac[1:0]][k];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= 3'd0;
      samples <= '0;
      frac    <= 3'd0;
      chroma  <= 1'b0;
      tag     <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      if (accept) begin
        samples <= in_samples;
        frac    <= in_frac;
        chroma  <= in_chroma;
        tag     <= in_tag;
      end
    end
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    in_ready   = 1'b0;
    mac_rst    = 1'b0;
    mac_en     = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    res_valid  = 1'b0;
    res_tag    = '0;
    busy       = 1'b0;
    if (rst) begin
      mac_rst = 1'b1;
    end else begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) state_next = CLR;
        end
        CLR: begin
          mac_rst    = 1'b1;
          state_next = TAP;
          k_next     = 3'd0;
        end
        TAP: begin
          mac_en = 1'b1;
          mac_a  = A_BITS'(sample_sel);
          mac_b  = B_BITS'(coef_sel);
          k_next = k + 3'd1;
          if (k == last_k) begin
            state_next = DONE;
            k_next     = 3'd0;
          end
        end
        DONE: begin
          res_valid  = 1'b1;
          res_tag    = tag;
          in_ready   = 1'b1;
          state_next = in_valid ? CLR : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_tap_seq.sv
// tb/tb_interp_tap_seq.sv - scoreboard bench for interp_tap_seq.
// Bench accumulator integrates mac_* traffic and is compared with queued expected sums.
module tb_interp_tap_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       in_samples;
  logic [2:0]         in_frac;
  logic               in_chroma;
  logic [7:0]         in_tag;
  logic               mac_rst;
  logic               mac_en;
  logic signed [15:0] mac_a;
  logic signed [7:0]  mac_b;
  logic               res_valid;
  logic [7:0]         res_tag;
  logic               busy;

  interp_tap_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_samples(in_samples), .in_frac(in_frac), .in_chroma(in_chroma), .in_tag(in_tag),
    .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .res_valid(res_valid), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int exp;
    int n;
    int due;
  } job_t;

  job_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;
  int   acc = 0;
  int   taps = 0;
  int   nclr = 0;
  int   results = 0;
  int   cur_exp = 0;

  int luma_c [4][8] = '{
    '{0, 0, 0, 64, 0, 0, 0, 0},
    '{-1, 4, -10, 58, 17, -5, 1, 0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{0, 1, -5, 17, 58, -10, 4, -1}
  };
  int chroma_c [8][4] = '{
    '{0, 64, 0, 0}, '{-2, 58, 10, -2}, '{-4, 54, 16, -2}, '{-6, 46, 28, -4},
    '{-4, 36, 36, -4}, '{-4, 28, 46, -6}, '{-2, 16, 54, -4}, '{-2, 10, 58, -2}
  };

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int model(input logic [127:0] s, input logic [2:0] f, input logic ch);
    int sum = 0;
    logic signed [15:0] v;
    for (int i = 0; i < (ch ? 4 : 8); i++) begin
      v = s[i*16 +: 16];
      sum += int'(v) * (ch ? chroma_c[f][i] : luma_c[f[1:0]][i]);
    end
    return sum;
  endfunction

  function automatic logic [127:0] fill(input int v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(v);
    return r;
  endfunction

  // Leaves in_valid high after the accepting edge so callers can chain jobs.
  task automatic send_job(input logic [127:0] s, input logic [2:0] f, input logic ch,
                          input logic [7:0] tag, input int exp);
    int waited = 0;
    in_samples = s;
    in_frac    = f;
    in_chroma  = ch;
    in_tag     = tag;
    cur_exp    = exp;
    in_valid   = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 40) begin
        check("accept_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    job_t j;
    ncyc++;
    if (rst) begin
      check("rst_mac_rst", mac_rst, 1);
      check("rst_mac_en", mac_en, 0);
      check("rst_mac_a", mac_a, 0);
      check("rst_mac_b", mac_b, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_tag", res_tag, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      sb.delete();
      acc = 0;
      taps = 0;
      nclr = 0;
    end else begin
      if (!mac_en) begin
        check("idle_mac_a", mac_a, 0);
        check("idle_mac_b", mac_b, 0);
      end
      if (mac_rst) begin
        acc = 0;
        taps = 0;
        nclr++;
      end
      if (mac_en) begin
        acc += int'(mac_a) * int'(mac_b);
        taps++;
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_res", 1, 0);
        end else begin
          j = sb.pop_front();
          check("res_tag", res_tag, j.tag);
          check("acc_sum", acc, j.exp);
          check("tap_count", taps, j.n);
          check("res_latency", ncyc, j.due);
          check("clr_per_job", nclr, 1);
        end
        nclr = 0;
        results++;
      end
      if (in_valid && in_ready) begin
        j.tag = int'(in_tag);
        j.exp = cur_exp;
        j.n   = in_chroma ? 4 : 8;
        j.due = ncyc + j.n + 2;
        sb.push_back(j);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [127:0] s;
    logic [2:0]   f;
    logic         ch;
    rst = 1'b1;
    in_valid = 1'b0;
    in_samples = '0;
    in_frac = 3'd0;
    in_chroma = 1'b0;
    in_tag = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    send_job(fill(100), 3'd2, 1'b0, 8'hA1, 6400);
    in_valid = 1'b0;
    repeat (12) @(posedge clk); #1;

    for (int i = 0; i < 8; i++) s[i*16 +: 16] = 16'(i);
    send_job(s, 3'd1, 1'b0, 8'hA2, 207);
    in_valid = 1'b0;
    repeat (12) @(posedge clk); #1;

    s = fill(-50);
    for (int i = 4; i < 8; i++) s[i*16 +: 16] = 16'(999);
    send_job(s, 3'd4, 1'b1, 8'hA3, -3200);
    in_valid = 1'b0;
    repeat (8) @(posedge clk); #1;

    s = {16'sd32767, -16'sd32768, 16'sd32767, -16'sd32768,
         -16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767};
    send_job(s, 3'd6, 1'b0, 8'hA4, -3669992);

    for (int t = 1; t <= 3; t++) begin
      for (int i = 0; i < 8; i++) s[i*16 +: 16] = 16'(i * 37 * t - 100);
      send_job(s, 3'd3, 1'b0, 8'(t), model(s, 3'd3, 1'b0));
    end
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) s[i*16 +: 16] = 16'($urandom);
      f  = 3'($urandom_range(0, 7));
      ch = 1'($urandom_range(0, 1));
      send_job(s, f, ch, 8'(16 + t), model(s, f, ch));
    end
    in_valid = 1'b0;
    repeat (14) @(posedge clk); #1;

    send_job(fill(5), 3'd1, 1'b0, 8'h55, 0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", in_ready, 1);
    check("busy_after_abort", busy, 0);
    @(posedge clk); #1;

    s = '0;
    s[3*16 +: 16] = 16'd77;
    send_job(s, 3'd0, 1'b0, 8'h77, 4928);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);

    check("result_count", results, 14);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
